vector_regfile_buffered: RTL and testbench

VECTOR_REGFILE_BUFFERED -- requirements
Module: vector_regfile_buffered

---
 rtl/vector_regfile_buffered.sv | 164 ++++++++++++++++
 tb/tb_vector_regfile_buffered.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_regfile_buffered.sv
// Banked vector register file: single-port banks with byte-enabled writes and
// credit-controlled reads that stream into per-queue operand FIFOs.
module vector_regfile_buffered #(
  parameter int unsigned NrBanks     = 8,
  parameter int unsigned NrQueues    = 4,
  parameter int unsigned NumWords    = 64,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned FifoDepth   = 2,
  localparam int unsigned AddrWidth  = $clog2(NumWords),
  localparam int unsigned StrbWidth  = DataWidth / 8,
  localparam int unsigned TgtWidth   = (NrQueues > 1) ? $clog2(NrQueues) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrBanks-1:0]                   req_i,
  output logic [NrBanks-1:0]                   gnt_o,
  input  logic [NrBanks-1:0][AddrWidth-1:0]    addr_i,
  input  logic [NrBanks-1:0][TgtWidth-1:0]     tgt_i,
  input  logic [NrBanks-1:0]                   wen_i,
  input  logic [NrBanks-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NrBanks-1:0][StrbWidth-1:0]    be_i,
  output logic [NrQueues-1:0][DataWidth-1:0]   operand_o,
  output logic [NrQueues-1:0]                  operand_valid_o,
  input  logic [NrQueues-1:0]                  operand_ready_i
);

  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

  logic [DataWidth-1:0] mem [NrBanks][NumWords];

  logic [NrQueues-1:0][CntWidth-1:0]  credit;
  logic [NrQueues-1:0]                pop;
  logic [NrQueues-1:0]                rd_avail;
  logic [NrQueues-1:0]                claimed;
  logic [NrBanks-1:0]                 rd_gnt;

  logic [NrQueues-1:0]                s0_valid;
  logic [NrQueues-1:0][DataWidth-1:0] s0_data;
  logic [NrQueues-1:0]                push_valid;
  logic [NrQueues-1:0][DataWidth-1:0] push_data;

  logic [DataWidth-1:0]               fifo_mem [NrQueues][FifoDepth];
  logic [NrQueues-1:0][PtrWidth-1:0]  wr_ptr;
  logic [NrQueues-1:0][PtrWidth-1:0]  rd_ptr;
  logic [NrQueues-1:0][CntWidth-1:0]  fifo_cnt;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // A pop in this cycle frees a slot early enough for a same-cycle grant.
  always_comb begin
    for (int q = 0; q < NrQueues; q++) begin
      operand_valid_o[q] = (fifo_cnt[q] != '0);
      operand_o[q]       = fifo_mem[q][rd_ptr[q]];
      pop[q]             = operand_valid_o[q] & operand_ready_i[q];
      rd_avail[q]        = (credit[q] != '0) | pop[q];
    end
  end

  always_comb begin
    gnt_o   = '0;
    rd_gnt  = '0;
    claimed = '0;
    if (!rst_i) begin
      for (int b = 0; b < NrBanks; b++) begin
        if (req_i[b] && wen_i[b]) begin
          gnt_o[b] = 1'b1;
        end else if (req_i[b] && (32'(tgt_i[b]) < NrQueues)) begin
          if (!claimed[tgt_i[b]] && rd_avail[tgt_i[b]]) begin
            gnt_o[b]            = 1'b1;
            rd_gnt[b]           = 1'b1;
            claimed[tgt_i[b]]   = 1'b1;
          end
        end
      end
    end
  end

  // At most one read per queue is granted, so each queue sees a single source bank.
  always_comb begin
    s0_valid = '0;
    s0_data  = '0;
    for (int q = 0; q < NrQueues; q++) begin
      for (int b = 0; b < NrBanks; b++) begin
        if (!s0_valid[q] && rd_gnt[b] && (tgt_i[b] == TgtWidth'(q))) begin
          s0_valid[q] = 1'b1;
          s0_data[q]  = mem[b][addr_i[b]];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NrBanks; b++) begin
      if (gnt_o[b] && wen_i[b]) begin
        for (int s = 0; s < StrbWidth; s++) begin
          if (be_i[b][s]) mem[b][addr_i[b]][8*s +: 8] <= wdata_i[b][8*s +: 8];
        end
      end
    end
  end

  generate
    if (ReadLatency <= 1) begin : g_direct
      assign push_valid = s0_valid;
      assign push_data  = s0_data;
    end else begin : g_pipe
      logic [NrQueues-1:0]                pv [ReadLatency-1];
      logic [NrQueues-1:0][DataWidth-1:0] pd [ReadLatency-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < ReadLatency - 1; i++) begin
            pv[i] <= '0;
            pd[i] <= '0;
          end
        end else begin
          pv[0] <= s0_valid;
          pd[0] <= s0_data;
          for (int i = 1; i < ReadLatency - 1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign push_valid = pv[ReadLatency-2];
      assign push_data  = pd[ReadLatency-2];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int q = 0; q < NrQueues; q++) begin
        credit[q]   <= CntWidth'(FifoDepth);
        wr_ptr[q]   <= '0;
        rd_ptr[q]   <= '0;
        fifo_cnt[q] <= '0;
      end
    end else begin
      for (int q = 0; q < NrQueues; q++) begin
        if (s0_valid[q] && !pop[q])      credit[q] <= credit[q] - CntWidth'(1);
        else if (!s0_valid[q] && pop[q]) credit[q] <= credit[q] + CntWidth'(1);

        if (push_valid[q]) wr_ptr[q] <= next_ptr(wr_ptr[q]);
        if (pop[q])        rd_ptr[q] <= next_ptr(rd_ptr[q]);

        if (push_valid[q] && !pop[q])      fifo_cnt[q] <= fifo_cnt[q] + CntWidth'(1);
        else if (!push_valid[q] && pop[q]) fifo_cnt[q] <= fifo_cnt[q] - CntWidth'(1);
      end
    end
  end

  // Credits guarantee a free slot whenever push_valid is raised.
  always_ff @(posedge clk_i) begin
    for (int q = 0; q < NrQueues; q++) begin
      if (push_valid[q]) fifo_mem[q][wr_ptr[q]] <= push_data[q];
    end
  end

endmodule

// File: tb/tb_vector_regfile_buffered.sv
// Randomized + directed bench for vector_regfile_buffered against a queue-based
// occupancy model (credit = depth - queued - in-flight).
module tb_vector_regfile_buffered;

  localparam int NB = 8;
  localparam int NQ = 3;
  localparam int NW = 64;
  localparam int DW = 64;
  localparam int RL = 2;
  localparam int FD = 2;
  localparam int AW = 6;
  localparam int TW = 2;
  localparam int SW = 8;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic [NB-1:0]             req_i;
  logic [NB-1:0]             gnt_o;
  logic [NB-1:0][AW-1:0]     addr_i;
  logic [NB-1:0][TW-1:0]     tgt_i;
  logic [NB-1:0]             wen_i;
  logic [NB-1:0][DW-1:0]     wdata_i;
  logic [NB-1:0][SW-1:0]     be_i;
  logic [NQ-1:0][DW-1:0]     operand_o;
  logic [NQ-1:0]             operand_valid_o;
  logic [NQ-1:0]             operand_ready_i;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  typedef struct { int q; logic [DW-1:0] d; int due; } flight_t;
  typedef struct { int q; logic [DW-1:0] d; } entry_t;

  logic [DW-1:0] mm [NB][NW];
  flight_t       fl[$];
  entry_t        mq[$];

  vector_regfile_buffered #(
    .NrBanks(NB), .NrQueues(NQ), .NumWords(NW), .DataWidth(DW),
    .ReadLatency(RL), .FifoDepth(FD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .tgt_i(tgt_i), .wen_i(wen_i), .wdata_i(wdata_i),
    .be_i(be_i), .operand_o(operand_o), .operand_valid_o(operand_valid_o),
    .operand_ready_i(operand_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic int qsize(input int q);
    int n = 0;
    foreach (mq[i]) if (mq[i].q == q) n++;
    return n;
  endfunction

  function automatic int fsize(input int q);
    int n = 0;
    foreach (fl[i]) if (fl[i].q == q) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] qhead(input int q);
    foreach (mq[i]) if (mq[i].q == q) return mq[i].d;
    return '0;
  endfunction

  task automatic popQ(input int q);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].q == q) begin
        mq.delete(i);
        return;
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic [NB-1:0] eg);
    checkVal("gnt", DW'(gnt_o), DW'(eg));
    for (int q = 0; q < NQ; q++) begin
      checkVal($sformatf("valid%0d", q), DW'(operand_valid_o[q]), DW'(qsize(q) > 0));
      if (qsize(q) > 0) checkVal($sformatf("data%0d", q), operand_o[q], qhead(q));
    end
  endtask

  task automatic clearInputs();
    req_i = '0; wen_i = '0; addr_i = '0; tgt_i = '0; wdata_i = '0; be_i = '0;
  endtask

  task automatic applyStimulus(input int b, input bit w, input int a, input int t,
                               input logic [DW-1:0] d, input logic [SW-1:0] e);
    req_i[b]   = 1'b1;
    wen_i[b]   = w;
    addr_i[b]  = AW'(a);
    tgt_i[b]   = TW'(t);
    wdata_i[b] = d;
    be_i[b]    = e;
  endtask

  // One clock cycle: predict grants from occupancy, compare, then advance the model.
  task automatic runCycle();
    logic [NB-1:0] eg;
    logic [NQ-1:0] pop;
    int            cred [NQ];
    bit            claimed [NQ];
    int            t;
    if (rst_i) begin
      mq.delete();
      fl.delete();
    end
    #1;
    eg = '0;
    for (int q = 0; q < NQ; q++) begin
      pop[q]     = !rst_i && (qsize(q) > 0) && operand_ready_i[q];
      cred[q]    = FD - qsize(q) - fsize(q);
      claimed[q] = 1'b0;
    end
    if (!rst_i) begin
      for (int b = 0; b < NB; b++) begin
        if (req_i[b]) begin
          if (wen_i[b]) eg[b] = 1'b1;
          else if (int'(tgt_i[b]) < NQ) begin
            t = int'(tgt_i[b]);
            if (!claimed[t] && (cred[t] > 0 || pop[t])) begin
              eg[b]      = 1'b1;
              claimed[t] = 1'b1;
            end
          end
        end
      end
    end
    checkOutput(eg);
    if (!rst_i) begin
      for (int b = 0; b < NB; b++)
        if (eg[b] && !wen_i[b])
          fl.push_back('{q: int'(tgt_i[b]), d: mm[b][addr_i[b]], due: cur + RL});
      for (int b = 0; b < NB; b++)
        if (eg[b] && wen_i[b])
          for (int s = 0; s < SW; s++)
            if (be_i[b][s]) mm[b][addr_i[b]][8*s +: 8] = wdata_i[b][8*s +: 8];
      for (int q = 0; q < NQ; q++) if (pop[q]) popQ(q);
    end
    cur++;
    while (fl.size() > 0 && fl[0].due <= cur) begin
      mq.push_back('{q: fl[0].q, d: fl[0].d});
      void'(fl.pop_front());
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain(input int n);
    clearInputs();
    operand_ready_i = '1;
    repeat (n) runCycle();
  endtask

  initial begin
    rst_i = 1'b1;
    clearInputs();
    operand_ready_i = '1;
    @(negedge clk_i);

    // Reset state, with a write request that must not be granted
    applyStimulus(0, 1'b1, 1, 0, 64'hDEAD, 8'hFF);
    #1;
    checkVal("rst_gnt", DW'(gnt_o), '0);
    checkVal("rst_valid", DW'(operand_valid_o), '0);
    runCycle();
    rst_i = 1'b0;

    // Fill every word of every bank so later reads are defined
    for (int a = 0; a < NW; a++) begin
      clearInputs();
      for (int b = 0; b < NB; b++) applyStimulus(b, 1'b1, a, 0, {$urandom, $urandom}, 8'hFF);
      runCycle();
    end

    // Full write then read to queue 2, check arrival exactly RL cycles later
    clearInputs();
    applyStimulus(0, 1'b1, 5, 0, 64'h1122334455667788, 8'hFF);
    runCycle();
    clearInputs();
    operand_ready_i = 3'b011;
    applyStimulus(0, 1'b0, 5, 2, '0, '0);
    #1;
    checkVal("r032_gnt", DW'(gnt_o[0]), 1);
    runCycle();
    clearInputs();
    #1;
    checkVal("r032_early", DW'(operand_valid_o[2]), 0);
    runCycle();
    #1;
    checkVal("r032_valid", DW'(operand_valid_o[2]), 1);
    checkVal("r032_data", operand_o[2], 64'h1122334455667788);
    operand_ready_i = '1;
    runCycle();

    // Partial byte-enable write
    clearInputs();
    applyStimulus(0, 1'b1, 5, 0, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    runCycle();
    clearInputs();
    operand_ready_i = 3'b011;
    applyStimulus(0, 1'b0, 5, 2, '0, '0);
    runCycle();
    clearInputs();
    runCycle();
    #1;
    checkVal("r033_data", operand_o[2], 64'h11223344AAAAAAAA);
    operand_ready_i = '1;
    runCycle();
    drain(3);

    // Same-target conflict: lower bank wins, higher bank follows next cycle
    clearInputs();
    operand_ready_i = 3'b110;
    applyStimulus(1, 1'b0, 7, 0, '0, '0);
    applyStimulus(3, 1'b0, 9, 0, '0, '0);
    #1;
    checkVal("r034_gnt_a", DW'(gnt_o), DW'(8'h02));
    runCycle();
    clearInputs();
    applyStimulus(3, 1'b0, 9, 0, '0, '0);
    #1;
    checkVal("r034_gnt_b", DW'(gnt_o), DW'(8'h08));
    runCycle();
    clearInputs();
    #1;
    checkVal("r034_first", operand_o[0], mm[1][7]);
    operand_ready_i = '1;
    runCycle();
    #1;
    checkVal("r034_second", operand_o[0], mm[3][9]);
    runCycle();
    drain(3);

    // Credit exhaustion on queue 1, release on pop
    clearInputs();
    operand_ready_i = 3'b101;
    applyStimulus(0, 1'b0, 5, 1, '0, '0);
    #1;
    checkVal("r035_gnt1", DW'(gnt_o[0]), 1);
    runCycle();
    clearInputs();
    applyStimulus(2, 1'b0, 11, 1, '0, '0);
    #1;
    checkVal("r035_gnt2", DW'(gnt_o[2]), 1);
    runCycle();
    clearInputs();
    applyStimulus(4, 1'b0, 13, 1, '0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal("r035_held", DW'(gnt_o[4]), 0);
      runCycle();
    end
    operand_ready_i = '1;
    #1;
    checkVal("r035_release", DW'(gnt_o[4]), 1);
    runCycle();
    drain(4);

    // Reset with reads in flight; contents survive, credits restored
    clearInputs();
    operand_ready_i = '0;
    applyStimulus(0, 1'b0, 5, 0, '0, '0);
    applyStimulus(1, 1'b0, 7, 2, '0, '0);
    runCycle();
    clearInputs();
    rst_i = 1'b1;
    applyStimulus(2, 1'b0, 3, 1, '0, '0);
    #1;
    checkVal("r036_rst_valid", DW'(operand_valid_o), '0);
    checkVal("r036_rst_gnt", DW'(gnt_o), '0);
    runCycle();
    rst_i = 1'b0;
    clearInputs();
    operand_ready_i = 3'b110;
    applyStimulus(5, 1'b0, 2, 1, '0, '0);
    #1;
    checkVal("r031_first_gnt", DW'(gnt_o[5]), 1);
    runCycle();
    clearInputs();
    #1;
    checkVal("r036_discard0", DW'(operand_valid_o[0]), 0);
    checkVal("r036_discard2", DW'(operand_valid_o[2]), 0);
    applyStimulus(0, 1'b0, 5, 0, '0, '0);
    runCycle();
    runCycle();
    #1;
    checkVal("r036_credit_out", DW'(gnt_o[0]), 0);
    checkVal("r036_retained", operand_o[0], 64'h11223344AAAAAAAA);
    runCycle();
    drain(5);

    // Out-of-range target is never granted and never produces data
    clearInputs();
    applyStimulus(6, 1'b0, 3, 3, '0, '0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkVal("r037_gnt", DW'(gnt_o), '0);
      runCycle();
    end
    clearInputs();
    #1;
    checkVal("r037_valid", DW'(operand_valid_o), '0);
    runCycle();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      clearInputs();
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 2) != 0)
          applyStimulus(b, $urandom_range(0, 2) == 0, $urandom_range(0, NW - 1),
                        $urandom_range(0, 3), {$urandom, $urandom}, SW'($urandom));
      operand_ready_i = NQ'($urandom);
      runCycle();
    end
    drain(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
